// File: rtl/r_format_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-format datapath.
// Owns PC and IR, decodes funct to an ALU opcode, and strobes the RF write once per retired instruction.
module r_format_seq_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt_req,
   input  logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [4:0]  rd_addr,
   output logic [4:0]  shamt,
   output logic [2:0]  alu_ctrl,
   output logic        rf_we,
   output logic        busy,
   output logic        illegal,
   output logic [15:0] retired_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_TRAP
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SLL = 3'd6;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [2:0]  alu_q, alu_d;
   logic        illegal_q, illegal_d;
   logic [15:0] cnt_q, cnt_d;
   logic        halt_q, halt_d;

   function automatic logic is_legal(input logic [31:0] ir);
      logic ok;
      ok = 1'b0;
      if (ir[31:26] == 6'd0) begin
         case (ir[5:0])
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02, 6'h00: ok = 1'b1;
            default:                                           ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
      logic [2:0] op;
      case (funct)
         6'h20:   op = ALU_ADD;
         6'h22:   op = ALU_SUB;
         6'h24:   op = ALU_AND;
         6'h25:   op = ALU_OR;
         6'h2A:   op = ALU_SLT;
         6'h02:   op = ALU_SRL;
         default: op = ALU_SLL;
      endcase
      return op;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= PC_RESET;
         ir_q      <= 32'd0;
         alu_q     <= ALU_ADD;
         illegal_q <= 1'b0;
         cnt_q     <= 16'd0;
         halt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_q     <= alu_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
         halt_q    <= halt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_d     = alu_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      halt_d    = halt_q;
      rf_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // halt_req is deliberately not latched here, so start+halt starts a run
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = instr;
            halt_d  = halt_q | halt_req;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            halt_d = halt_q | halt_req;
            if (is_legal(ir_q)) begin
               alu_d   = funct_to_alu(ir_q[5:0]);
               state_d = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_EXEC: begin
            halt_d  = halt_q | halt_req;
            state_d = S_WB;
         end
         S_WB: begin
            // a halt arriving in WB still lets this instruction retire, then stops
            rf_we = (ir_q[15:11] != 5'd0);
            pc_d  = pc_q + PC_STEP;
            cnt_d = cnt_q + 16'd1;
            if (halt_q || halt_req) begin
               halt_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign pc_out      = pc_q;
   assign rs_addr     = ir_q[25:21];
   assign rt_addr     = ir_q[20:16];
   assign rd_addr     = ir_q[15:11];
   assign shamt       = ir_q[10:6];
   assign alu_ctrl    = alu_q;
   assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC)  || (state_q == S_WB);
   assign illegal     = illegal_q;
   assign retired_cnt = cnt_q;

endmodule
